// File: rtl/soc_periph_arbiter.sv
// soc_periph_arbiter
// Round-robin arbiter that lets several bus masters share a single peripheral
// port. One transaction is in flight at a time: the winning master's request
// is registered, decoded to a one-hot slave select, forwarded to the slave,
// and the response (or a decode/timeout error) is returned to that master.

module soc_periph_arbiter #(
  parameter int unsigned NumMasters    = 2,
  parameter bit          CLICEnable    = 1'b0,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,

  // master side
  input  logic [NumMasters-1:0]       req_i,
  input  logic [NumMasters-1:0][63:0] addr_i,
  input  logic [NumMasters-1:0]       we_i,
  input  logic [NumMasters-1:0][63:0] wdata_i,
  output logic [NumMasters-1:0]       gnt_o,
  output logic [NumMasters-1:0]       rvalid_o,
  output logic [63:0]                 rdata_o,
  output logic                        err_o,

  // slave side
  output logic [10:0]                 slv_req_o,
  output logic [63:0]                 slv_addr_o,
  output logic                        slv_we_o,
  output logic [63:0]                 slv_wdata_o,
  input  logic                        slv_gnt_i,
  input  logic                        slv_rvalid_i,
  input  logic [63:0]                 slv_rdata_i,
  input  logic                        slv_err_i
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam int          NM        = int'(NumMasters);
  localparam int          MidW      = (NumMasters > 1) ? $clog2(NumMasters) : 1;
  localparam int          NumSlaves = 11;
  localparam int          SlvClic   = 0;
  localparam logic [7:0]  TmoLimit  = 8'(TimeoutCycles);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
  localparam logic [1:0] DECERR = 2'd3;

  // Address map, indexed by slave select bit. Held in 65 bits so that
  // base + length can be formed without wrapping at the top of the 64-bit space.
  localparam logic [64:0] RegionBase [NumSlaves] = '{
    65'h0_5000_0000,  // CLIC
    65'h0_8000_0000,  // DRAM
    65'h0_4000_0000,  // GPIO
    65'h0_3000_0000,  // Ethernet
    65'h0_2000_0000,  // SPI
    65'h0_1800_0000,  // Timer
    65'h0_1000_0000,  // UART
    65'h0_0C00_0000,  // PLIC
    65'h0_0200_0000,  // CLINT
    65'h0_0001_0000,  // ROM
    65'h0_0000_0000   // Debug
  };

  localparam logic [64:0] RegionLen [NumSlaves] = '{
    65'h0_03FF_FFFF,  // CLIC
    65'h0_4000_0000,  // DRAM
    65'h0_0000_1000,  // GPIO
    65'h0_0001_0000,  // Ethernet
    65'h0_0080_0000,  // SPI
    65'h0_0000_1000,  // Timer
    65'h0_0000_1000,  // UART
    65'h0_03FF_FFFF,  // PLIC
    65'h0_000C_0000,  // CLINT
    65'h0_0001_0000,  // ROM
    65'h0_0000_1000   // Debug
  };

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]      state_q, state_d;
  logic [MidW-1:0] rr_q, rr_d;       // master with highest priority next time
  logic [7:0]      cnt_q, cnt_d;     // cycles spent in REQ/RESP
  logic [MidW-1:0] mid_q;            // master owning the current transaction
  logic [3:0]      idx_q;            // decoded slave index
  logic [63:0]     addr_q;
  logic            we_q;
  logic [63:0]     wdata_q;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [2*NumMasters-1:0] req_rot;
  logic                    arb_valid;
  logic [MidW-1:0]         arb_id;
  int                      arb_sum;
  logic                    grant;

  // Rotate requests so bit 0 is the priority master, then take the first one set.
  // NOTE: every variable assigned in an always_comb gets a default at the top;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    req_rot   = {req_i, req_i} >> rr_q;
    arb_valid = 1'b0;
    arb_id    = '0;
    arb_sum   = 0;
    for (int k = 0; k < NM; k++) begin
      if (!arb_valid && req_rot[k]) begin
        arb_valid = 1'b1;
        arb_sum   = int'(rr_q) + k;
        if (arb_sum >= NM) begin
          arb_sum = arb_sum - NM;
        end
        arb_id = MidW'(arb_sum);
      end
    end
  end

  // A grant is only possible from IDLE and never while reset is held.
  assign grant = rst_ni && (state_q == IDLE) && arb_valid;

  // One-hot grant to the winning master.
  always_comb begin
    gnt_o = '0;
    if (grant) begin
      gnt_o[arb_id] = 1'b1;
    end
  end

  // Priority moves to the master after the one just granted.
  always_comb begin
    rr_d = rr_q;
    if (grant) begin
      if (arb_id == MidW'(NumMasters - 1)) begin
        rr_d = '0;
      end else begin
        rr_d = arb_id + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Address decode of the winning master's address
  // ---------------------------------------------------------------------------
  logic [64:0] dec_addr;
  logic        dec_hit;
  logic [3:0]  dec_idx;

  // Regions are disjoint, so at most one matches.
  always_comb begin
    dec_addr = {1'b0, addr_i[arb_id]};
    dec_hit  = 1'b0;
    dec_idx  = '0;
    for (int s = 0; s < NumSlaves; s++) begin
      if ((dec_addr >= RegionBase[s]) &&
          (dec_addr <  RegionBase[s] + RegionLen[s]) &&
          ((s != SlvClic) || CLICEnable)) begin
        dec_hit = 1'b1;
        dec_idx = 4'(s);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Completion / timeout
  // ---------------------------------------------------------------------------
  logic busy;
  logic timeout;
  logic complete;
  logic resp_fire;

  assign busy      = (state_q == REQ) || (state_q == RESP);
  assign complete  = (state_q == RESP) && slv_rvalid_i;
  // A real completion in the timeout cycle takes precedence over the timeout.
  assign timeout   = busy && (cnt_q >= TmoLimit) && !complete;
  assign resp_fire = complete || timeout || (state_q == DECERR);

  // Next-state logic for the transaction FSM and the timeout counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = dec_hit ? REQ : DECERR;
          cnt_d   = '0;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (timeout) begin
          state_d = IDLE;
        end else if (slv_gnt_i) begin
          state_d = RESP;
        end
      end
      RESP: begin
        cnt_d = cnt_q + 8'd1;
        if (complete || timeout) begin
          state_d = IDLE;
        end
      end
      DECERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state: FSM, round-robin pointer and timeout counter.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the granted master's request for the duration of the transaction.
  // NOTE: these data registers are reset as well because they drive slave-side
  // outputs that must read zero while reset is held.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mid_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (grant) begin
      mid_q   <= arb_id;
      idx_q   <= dec_idx;
      addr_q  <= addr_i[arb_id];
      we_q    <= we_i[arb_id];
      wdata_q <= wdata_i[arb_id];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign slv_addr_o  = addr_q;
  assign slv_we_o    = we_q;
  assign slv_wdata_o = wdata_q;

  // Slave request is held until accepted and withdrawn on timeout.
  always_comb begin
    slv_req_o = '0;
    if ((state_q == REQ) && !timeout) begin
      slv_req_o[idx_q] = 1'b1;
    end
  end

  // Response to the owning master; data and error are zero outside a response.
  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    err_o    = 1'b0;
    if (resp_fire) begin
      rvalid_o[mid_q] = 1'b1;
      if (complete) begin
        rdata_o = slv_rdata_i;
        err_o   = slv_err_i;
      end else begin
        err_o   = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_soc_periph_arbiter.sv
// Testbench for soc_periph_arbiter. Two instances: dut 0 with default
// parameters (CLIC unmapped, long timeout) and dut 1 with CLIC enabled and a
// 4-cycle timeout. Stimulus pushes expected grants, slave requests and
// responses into queues; a negedge monitor pops and compares them.

module tb_soc_periph_arbiter;

  typedef struct {
    int         d;
    logic [1:0] vec;
    int         cyc;
  } gnt_t;

  typedef struct {
    int          d;
    logic [10:0] req;
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    int          cyc;
  } slv_t;

  typedef struct {
    int          d;
    logic [1:0]  vec;
    logic [63:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  logic clk;
  logic [1:0] rst_n;

  logic [1:0][1:0]        req;
  logic [1:0][1:0][63:0]  addr;
  logic [1:0][1:0]        we;
  logic [1:0][1:0][63:0]  wdata;
  logic [1:0]             slv_gnt;
  logic [1:0]             slv_rvalid;
  logic [1:0][63:0]       slv_rdata;
  logic [1:0]             slv_err;

  wire [1:0][1:0]         gnt;
  wire [1:0][1:0]         rvalid;
  wire [1:0][63:0]        rdata;
  wire [1:0]              err;
  wire [1:0][10:0]        slv_req;
  wire [1:0][63:0]        slv_addr;
  wire [1:0]              slv_we;
  wire [1:0][63:0]        slv_wdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tmo [2] = '{255, 4};

  gnt_t gq[$];
  slv_t sq[$];
  rsp_t rq[$];
  gnt_t ge;
  slv_t se;
  rsp_t re;

  soc_periph_arbiter #(.NumMasters(2), .CLICEnable(1'b0), .TimeoutCycles(255)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n[0]),
    .req_i(req[0]), .addr_i(addr[0]), .we_i(we[0]), .wdata_i(wdata[0]),
    .gnt_o(gnt[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]),
    .slv_req_o(slv_req[0]), .slv_addr_o(slv_addr[0]), .slv_we_o(slv_we[0]),
    .slv_wdata_o(slv_wdata[0]), .slv_gnt_i(slv_gnt[0]), .slv_rvalid_i(slv_rvalid[0]),
    .slv_rdata_i(slv_rdata[0]), .slv_err_i(slv_err[0])
  );

  soc_periph_arbiter #(.NumMasters(2), .CLICEnable(1'b1), .TimeoutCycles(4)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n[1]),
    .req_i(req[1]), .addr_i(addr[1]), .we_i(we[1]), .wdata_i(wdata[1]),
    .gnt_o(gnt[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]),
    .slv_req_o(slv_req[1]), .slv_addr_o(slv_addr[1]), .slv_we_o(slv_we[1]),
    .slv_wdata_o(slv_wdata[1]), .slv_gnt_i(slv_gnt[1]), .slv_rvalid_i(slv_rvalid[1]),
    .slv_rdata_i(slv_rdata[1]), .slv_err_i(slv_err[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: compares every grant, new slave request and response.
  initial begin
    logic [1:0][10:0] prev_req;
    logic [1:0][63:0] prev_addr;
    prev_req  = '0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (gnt[d] != 2'b00) begin
          if (gq.size() == 0) begin
            check("gnt_unexpected", 64'(gnt[d]), 64'h0);
          end else begin
            ge = gq.pop_front();
            check("gnt_dut", 64'(d), 64'(ge.d));
            check("gnt_vec", 64'(gnt[d]), 64'(ge.vec));
            check("gnt_cycle", 64'(cyc), 64'(ge.cyc));
          end
        end
        if (slv_req[d] != 11'h0 && prev_req[d] == 11'h0) begin
          if (sq.size() == 0) begin
            check("slv_req_unexpected", 64'(slv_req[d]), 64'h0);
          end else begin
            se = sq.pop_front();
            check("slv_dut", 64'(d), 64'(se.d));
            check("slv_req", 64'(slv_req[d]), 64'(se.req));
            check("slv_addr", slv_addr[d], se.addr);
            check("slv_we", 64'(slv_we[d]), 64'(se.we));
            check("slv_wdata", slv_wdata[d], se.wdata);
            check("slv_cycle", 64'(cyc), 64'(se.cyc));
          end
        end else if (slv_req[d] != 11'h0) begin
          check("slv_req_stable", 64'(slv_req[d]), 64'(prev_req[d]));
          check("slv_addr_stable", slv_addr[d], prev_addr[d]);
        end
        prev_req[d]  = slv_req[d];
        prev_addr[d] = slv_addr[d];
        if (rvalid[d] != 2'b00) begin
          if (rq.size() == 0) begin
            check("rsp_unexpected", 64'(rvalid[d]), 64'h0);
          end else begin
            re = rq.pop_front();
            check("rsp_dut", 64'(d), 64'(re.d));
            check("rsp_vec", 64'(rvalid[d]), 64'(re.vec));
            check("rsp_rdata", rdata[d], re.rdata);
            check("rsp_err", 64'(err[d]), 64'(re.err));
            check("rsp_cycle", 64'(cyc), 64'(re.cyc));
          end
        end else begin
          check("idle_rdata", rdata[d], 64'h0);
          check("idle_err", 64'(err[d]), 64'h0);
        end
      end
    end
  end

  // All outputs of one instance must read zero.
  task automatic check_zero(input int d);
    check("rst_gnt", 64'(gnt[d]), 64'h0);
    check("rst_rvalid", 64'(rvalid[d]), 64'h0);
    check("rst_slv_req", 64'(slv_req[d]), 64'h0);
    check("rst_slv_we", 64'(slv_we[d]), 64'h0);
    check("rst_err", 64'(err[d]), 64'h0);
    check("rst_slv_addr", slv_addr[d], 64'h0);
    check("rst_slv_wdata", slv_wdata[d], 64'h0);
    check("rst_rdata", rdata[d], 64'h0);
  endtask

  // One transaction: masters in mask request in the current cycle, master m is
  // expected to win. slv < 0 means unmapped. gd: extra REQ cycles before the
  // slave accepts (-1 never); rd: extra RESP cycles before rvalid (-1 never).
  task automatic run_txn(input int d, input logic [1:0] mask, input int m,
                         input logic [63:0] a, input logic w, input logic [63:0] wd,
                         input int slv, input int gd, input int rd,
                         input logic [63:0] rdv, input logic erv);
    int gc, t_gnt, t_rv, t_to, t_end;
    gnt_t g;
    slv_t s;
    rsp_t r;
    gc = cyc;
    for (int i = 0; i < 2; i++) begin
      req[d][i]   = mask[i];
      addr[d][i]  = a;
      we[d][i]    = w;
      wdata[d][i] = wd ^ 64'(i);
    end
    t_to  = gc + 1 + tmo[d];
    t_gnt = -1;
    t_rv  = -1;
    if (slv >= 0 && gd >= 0) begin
      t_gnt = gc + 1 + gd;
      if (rd >= 0) t_rv = t_gnt + 1 + rd;
    end
    g.d = d; g.vec = 2'(1 << m); g.cyc = gc;
    gq.push_back(g);
    r.d = d; r.vec = 2'(1 << m);
    if (slv < 0) begin
      t_end = gc + 1; r.rdata = 64'h0; r.err = 1'b1;
    end else if (t_rv >= 0 && t_rv <= t_to) begin
      t_end = t_rv; r.rdata = rdv; r.err = erv;
    end else begin
      t_end = t_to; r.rdata = 64'h0; r.err = 1'b1;
    end
    r.cyc = t_end;
    rq.push_back(r);
    if (slv >= 0) begin
      s.d = d; s.req = 11'(1 << slv); s.addr = a; s.we = w; s.wdata = wd ^ 64'(m);
      s.cyc = gc + 1;
      sq.push_back(s);
    end
    @(posedge clk); #1;
    req[d] = 2'b00;
    while (cyc <= t_end) begin
      slv_gnt[d]    = (cyc == t_gnt) || (slv < 0);
      slv_rvalid[d] = (cyc == t_rv) || (gd > 0 && cyc == gc + 1);
      slv_rdata[d]  = rdv;
      slv_err[d]    = (cyc == t_rv) ? erv : 1'b1;
      @(posedge clk); #1;
    end
    slv_gnt[d]    = 1'b0;
    slv_rvalid[d] = 1'b0;
    slv_rdata[d]  = 64'h0;
    slv_err[d]    = 1'b0;
  endtask

  typedef struct {
    logic [63:0] a;
    int          slv;
  } dec_vec_t;

  dec_vec_t dec_tab [22] = '{
    '{64'h0000_0000, 10}, '{64'h0000_0FFF, 10}, '{64'h0000_1000, -1},
    '{64'h0001_0000, 9},  '{64'h0001_FFFF, 9},  '{64'h0002_0000, -1},
    '{64'h0200_0000, 8},  '{64'h020B_FFFF, 8},  '{64'h020C_0000, -1},
    '{64'h0C00_0000, 7},  '{64'h0FFF_FFFE, 7},  '{64'h0FFF_FFFF, -1},
    '{64'h1800_0000, 5},  '{64'h1800_1000, -1}, '{64'h207F_FFFF, 4},
    '{64'h3000_FFFF, 3},  '{64'h4000_0FFF, 2},  '{64'h4000_1000, -1},
    '{64'h7FFF_FFFF, -1}, '{64'h8000_0000, 1},  '{64'h1_1000_0000, -1},
    '{64'hFFFF_FFFF_FFFF_FFFF, -1}
  };

  initial begin
    int gc;
    gnt_t g;
    slv_t s;
    rst_n      = 2'b00;
    req        = '0;
    addr       = '0;
    we         = '0;
    wdata      = '0;
    slv_gnt    = '0;
    slv_rvalid = '0;
    slv_rdata  = '0;
    slv_err    = '0;

    // Requests during reset must not be granted.
    @(posedge clk); #1;
    req = '1;
    @(posedge clk); #1;
    check_zero(0);
    check_zero(1);
    req = '0;
    rst_n = 2'b11;
    @(posedge clk); #1;

    // Both masters request twice: round-robin gives M0 then M1.
    run_txn(0, 2'b11, 0, 64'h1000_0000, 1'b0, 64'h11, 6, 0, 0, 64'hDEAD, 1'b0);
    run_txn(0, 2'b11, 1, 64'h4000_0000, 1'b1, 64'h22, 2, 0, 0, 64'h1234, 1'b0);
    // Unmapped write from M1.
    run_txn(0, 2'b10, 1, 64'h6000_0000, 1'b1, 64'h33, -1, 0, 0, 64'h0, 1'b0);
    // CLIC unmapped when disabled; DRAM top edge and first address past it.
    run_txn(0, 2'b01, 0, 64'h5000_0000, 1'b0, 64'h44, -1, 0, 0, 64'h0, 1'b0);
    run_txn(0, 2'b01, 0, 64'hBFFF_FFFF, 1'b0, 64'h55, 1, 0, 0, 64'hCAFE, 1'b0);
    run_txn(0, 2'b01, 0, 64'hC000_0000, 1'b0, 64'h66, -1, 0, 0, 64'h0, 1'b0);

    // Region boundaries, alternating masters, varied slave latency and errors.
    for (int i = 0; i < 22; i++) begin
      run_txn(0, 2'(1 << (i % 2)), i % 2, dec_tab[i].a, 1'(i % 2), 64'(i) << 8,
              dec_tab[i].slv, i % 3, i % 2, dec_tab[i].a ^ 64'hA5A5_0000, 1'(i % 4 == 3));
    end

    // Reset in RESP: everything drops immediately; pointer returns to M0.
    gc = cyc;
    req[0][0] = 1'b1; addr[0][0] = 64'h1000_0010; we[0][0] = 1'b1; wdata[0][0] = 64'h77;
    g.d = 0; g.vec = 2'b01; g.cyc = gc;
    gq.push_back(g);
    s.d = 0; s.req = 11'h040; s.addr = 64'h1000_0010; s.we = 1'b1; s.wdata = 64'h77;
    s.cyc = gc + 1;
    sq.push_back(s);
    @(posedge clk); #1;
    req[0] = 2'b00;
    slv_gnt[0] = 1'b1;
    @(posedge clk); #1;
    slv_gnt[0] = 1'b0;
    #2;
    rst_n[0] = 1'b0;
    req[0] = 2'b11;
    slv_rvalid[0] = 1'b1;
    slv_rdata[0] = 64'hFFFF;
    #1;
    check_zero(0);
    @(posedge clk); #1;
    check_zero(0);
    req[0] = 2'b00;
    slv_rvalid[0] = 1'b0;
    slv_rdata[0] = 64'h0;
    rst_n[0] = 1'b1;
    @(posedge clk); #1;
    run_txn(0, 2'b11, 0, 64'h1000_0020, 1'b0, 64'h88, 6, 0, 0, 64'hBEEF, 1'b0);
    run_txn(0, 2'b11, 1, 64'h1000_0020, 1'b0, 64'h99, 6, 0, 0, 64'hF00D, 1'b1);

    // dut 1: CLIC mapped, edges of the CLIC region.
    run_txn(1, 2'b01, 0, 64'h5000_0000, 1'b0, 64'h10, 0, 0, 0, 64'h5151, 1'b0);
    run_txn(1, 2'b10, 1, 64'h53FF_FFFE, 1'b1, 64'h20, 0, 0, 0, 64'h5252, 1'b0);
    run_txn(1, 2'b01, 0, 64'h53FF_FFFF, 1'b0, 64'h30, -1, 0, 0, 64'h0, 1'b0);
    // Timeout with 4 cycles: slave accepts but never responds, then never accepts.
    run_txn(1, 2'b01, 0, 64'h1000_0000, 1'b0, 64'h40, 6, 0, -1, 64'hBAD0, 1'b0);
    run_txn(1, 2'b10, 1, 64'h1000_0000, 1'b0, 64'h50, 6, -1, -1, 64'hBAD1, 1'b0);
    // Response in the same cycle the timeout would fire: response wins.
    run_txn(1, 2'b01, 0, 64'h1800_0000, 1'b0, 64'h60, 5, 1, 2, 64'h600D, 1'b0);
    // Normal transaction after the timeouts.
    run_txn(1, 2'b10, 1, 64'h8000_1000, 1'b1, 64'h70, 1, 0, 0, 64'h7777, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("gnt_queue_drained", 64'(gq.size()), 64'h0);
    check("slv_queue_drained", 64'(sq.size()), 64'h0);
    check("rsp_queue_drained", 64'(rq.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
